// File: rtl/operand_fetch_stage_pkg.sv
// rtl/operand_fetch_stage_pkg.sv - shared CPU constants, MD encodings and operand-fetch FSM states
// Purpose: widths, write-back mode encodings and state encoding shared by the
//          operand fetch stage, its interface and the bypass mux.
// Ports: none (package).
// Config: OF_BYPASS_EN selects whether ST_HOLD or ST_WAIT_EX/ST_WAIT_WB are used.
package operand_fetch_stage_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    localparam logic [1:0] MD_FUNC  = 2'd0;
    localparam logic [1:0] MD_DATA  = 2'd1;
    localparam logic [1:0] MD_NXORV = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_WAIT_EX = 2'd2,
        ST_WAIT_WB = 2'd3
    } of_state_e;

    // A producer hits a source when it writes that register; r0 never hits.
    function automatic logic src_hit(input logic we, input logic [REG_AW-1:0] wa,
                                     input logic [REG_AW-1:0] ra);
        return we && (wa == ra) && (ra != '0);
    endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// rtl/operand_fetch_stage_if.sv - bundle of decode, register-file, producer and result signals
// Purpose: groups every non-clock/reset signal of the operand fetch stage.
// Ports: slave = the stage (consumes decode/producer inputs, drives *_OUT and STALL);
//        master = the surrounding pipeline.
interface operand_fetch_stage_if;
    import operand_fetch_stage_pkg::*;

    logic              IR_VALID;
    logic              FLUSH;
    logic [REG_AW-1:0] AA;
    logic [REG_AW-1:0] BA;
    logic [REG_AW-1:0] DA;
    logic              RW;
    logic [1:0]        MD;
    logic [DATA_W-1:0] A_Data;
    logic [DATA_W-1:0] B_Data;
    logic              EX_RW;
    logic [REG_AW-1:0] EX_DA;
    logic [1:0]        EX_MD;
    logic [DATA_W-1:0] EX_FUNC_OUT;
    logic              RW_1;
    logic [REG_AW-1:0] DA_1;
    logic [DATA_W-1:0] Bus_D;
    logic [DATA_W-1:0] A_OUT;
    logic [DATA_W-1:0] B_OUT;
    logic [REG_AW-1:0] DA_OUT;
    logic              RW_OUT;
    logic [1:0]        MD_OUT;
    logic              VALID_OUT;
    logic              STALL;

    modport slave (
        input  IR_VALID, FLUSH, AA, BA, DA, RW, MD, A_Data, B_Data,
               EX_RW, EX_DA, EX_MD, EX_FUNC_OUT, RW_1, DA_1, Bus_D,
        output A_OUT, B_OUT, DA_OUT, RW_OUT, MD_OUT, VALID_OUT, STALL
    );

    modport master (
        output IR_VALID, FLUSH, AA, BA, DA, RW, MD, A_Data, B_Data,
               EX_RW, EX_DA, EX_MD, EX_FUNC_OUT, RW_1, DA_1, Bus_D,
        input  A_OUT, B_OUT, DA_OUT, RW_OUT, MD_OUT, VALID_OUT, STALL
    );

endinterface

// File: rtl/operand_fetch_stage_bypass_mux.sv
// rtl/operand_fetch_stage_bypass_mux.sv - per-operand source selection (r0 / EX / WB / register file)
// Purpose: picks one operand value. Priority: address 0 -> 0; EX producer
//          (not a load) -> ex_data; WB producer -> wb_data; else rf_data.
// Ports: addr/rf_data = source address and register-file read data;
//        ex_* / wb_* = producer fields with per-stage forward enables; operand = result.
module operand_bypass_mux
    import operand_fetch_stage_pkg::*;
(
    input  logic [REG_AW-1:0] addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_fwd_en,
    input  logic              ex_rw,
    input  logic [REG_AW-1:0] ex_da,
    input  logic [1:0]        ex_md,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              wb_fwd_en,
    input  logic              wb_rw,
    input  logic [REG_AW-1:0] wb_da,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] operand
);

    always_comb begin
        operand = rf_data;
        if (addr == '0) begin
            operand = '0;
        end else if (ex_fwd_en && src_hit(ex_rw, ex_da, addr) && (ex_md != MD_DATA)) begin
            // A load in EX has no data yet; that case is a hazard, not a forward.
            operand = ex_data;
        end else if (wb_fwd_en && src_hit(wb_rw, wb_da, addr)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - operand fetch pipeline stage with hazard stall and optional bypass
// Purpose: selects A/B operands, detects hazards, drives STALL and registers
//          operands plus destination fields into the next stage.
// Ports: CLK (rising edge), reset (sync, active-high), bus (operand_fetch_stage_if.slave).
// Config: `define OF_BYPASS_EN for EX/WB forwarding with one-cycle load-use HOLD;
//         otherwise operands come only from the register file and any producer
//         match stalls through the RUN/WAIT_EX/WAIT_WB sequence.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
(
    input  logic                  CLK,
    input  logic                  reset,
    operand_fetch_stage_if.slave  bus
);

    of_state_e         state_q, state_d;
    logic [DATA_W-1:0] a_out_q, a_out_d;
    logic [DATA_W-1:0] b_out_q, b_out_d;
    logic [REG_AW-1:0] da_out_q, da_out_d;
    logic              rw_out_q, rw_out_d;
    logic [1:0]        md_out_q, md_out_d;
    logic              valid_out_q, valid_out_d;

    logic              stall_raw;
    logic              ex_fwd_en;
    logic              wb_fwd_en;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

`ifdef OF_BYPASS_EN
    logic load_use;

    // While holding, the load has moved on to WB; EX now carries the bubble.
    assign ex_fwd_en = (state_q != ST_HOLD);
    assign wb_fwd_en = 1'b1;
    assign load_use  = bus.IR_VALID && bus.EX_RW && (bus.EX_MD == MD_DATA) &&
                       (src_hit(1'b1, bus.EX_DA, bus.AA) || src_hit(1'b1, bus.EX_DA, bus.BA));
`else
    logic ex_match;
    logic wb_match;

    assign ex_fwd_en = 1'b0;
    assign wb_fwd_en = 1'b0;
    assign ex_match  = bus.IR_VALID &&
                       (src_hit(bus.EX_RW, bus.EX_DA, bus.AA) || src_hit(bus.EX_RW, bus.EX_DA, bus.BA));
    assign wb_match  = bus.IR_VALID &&
                       (src_hit(bus.RW_1, bus.DA_1, bus.AA) || src_hit(bus.RW_1, bus.DA_1, bus.BA));
`endif

    operand_bypass_mux u_mux_a (
        .addr      (bus.AA),
        .rf_data   (bus.A_Data),
        .ex_fwd_en (ex_fwd_en),
        .ex_rw     (bus.EX_RW),
        .ex_da     (bus.EX_DA),
        .ex_md     (bus.EX_MD),
        .ex_data   (bus.EX_FUNC_OUT),
        .wb_fwd_en (wb_fwd_en),
        .wb_rw     (bus.RW_1),
        .wb_da     (bus.DA_1),
        .wb_data   (bus.Bus_D),
        .operand   (sel_a)
    );

    operand_bypass_mux u_mux_b (
        .addr      (bus.BA),
        .rf_data   (bus.B_Data),
        .ex_fwd_en (ex_fwd_en),
        .ex_rw     (bus.EX_RW),
        .ex_da     (bus.EX_DA),
        .ex_md     (bus.EX_MD),
        .ex_data   (bus.EX_FUNC_OUT),
        .wb_fwd_en (wb_fwd_en),
        .wb_rw     (bus.RW_1),
        .wb_da     (bus.DA_1),
        .wb_data   (bus.Bus_D),
        .operand   (sel_b)
    );

    always_comb begin
        state_d   = state_q;
        stall_raw = 1'b0;
`ifdef OF_BYPASS_EN
        if (state_q == ST_RUN) begin
            if (load_use) begin
                stall_raw = 1'b1;
                state_d   = ST_HOLD;
            end
        end else begin
            state_d = ST_RUN;
        end
`else
        // EX producer needs two cycles to land in the register file, WB one.
        // WAIT_WB is the cycle the written value first becomes readable.
        case (state_q)
            ST_RUN: begin
                if (ex_match) begin
                    stall_raw = 1'b1;
                    state_d   = ST_WAIT_EX;
                end else if (wb_match) begin
                    stall_raw = 1'b1;
                    state_d   = ST_WAIT_WB;
                end
            end
            ST_WAIT_EX: begin
                stall_raw = 1'b1;
                state_d   = ST_WAIT_WB;
            end
            default: state_d = ST_RUN;
        endcase
`endif
        if (bus.FLUSH) begin
            state_d = ST_RUN;
        end

        a_out_d     = a_out_q;
        b_out_d     = b_out_q;
        da_out_d    = da_out_q;
        rw_out_d    = rw_out_q;
        md_out_d    = md_out_q;
        valid_out_d = valid_out_q;
        if (bus.FLUSH || stall_raw) begin
            valid_out_d = 1'b0;
            rw_out_d    = 1'b0;
        end else begin
            a_out_d     = sel_a;
            b_out_d     = sel_b;
            da_out_d    = bus.DA;
            md_out_d    = bus.MD;
            valid_out_d = bus.IR_VALID;
            rw_out_d    = bus.RW && bus.IR_VALID;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= ST_RUN;
            a_out_q     <= '0;
            b_out_q     <= '0;
            da_out_q    <= '0;
            rw_out_q    <= 1'b0;
            md_out_q    <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            da_out_q    <= da_out_d;
            rw_out_q    <= rw_out_d;
            md_out_q    <= md_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.STALL     = stall_raw && !bus.FLUSH && !reset;
    assign bus.A_OUT     = a_out_q;
    assign bus.B_OUT     = b_out_q;
    assign bus.DA_OUT    = da_out_q;
    assign bus.RW_OUT    = rw_out_q;
    assign bus.MD_OUT    = md_out_q;
    assign bus.VALID_OUT = valid_out_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;
    import operand_fetch_stage_pkg::*;

    typedef struct {
        logic        flush;
        logic        irv;
        logic [4:0]  aa, ba, da;
        logic        rw;
        logic [1:0]  md;
        logic        ex_rw;
        logic [4:0]  ex_da;
        logic [1:0]  ex_md;
        logic [31:0] ex_func;
        logic        rw_1;
        logic [4:0]  da_1;
        logic [31:0] bus_d;
        logic [31:0] exp_a, exp_b;
        logic        exp_valid, exp_rw, exp_stall;
    } vec_t;

    logic CLK = 1'b0;
    logic reset;
    operand_fetch_stage_if ifc ();
    operand_fetch_stage dut (.CLK(CLK), .reset(reset), .bus(ifc));

    always #5 CLK = ~CLK;

    logic [31:0] rf [32];
    assign ifc.A_Data = rf[ifc.AA];
    assign ifc.B_Data = rf[ifc.BA];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] rfv(input int i);
        if (i == 0)  return 32'hDEADBEEF;
        if (i == 22) return 32'h45A0F123;
        return 32'h1000_0000 | (i << 8) | i;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t blank();
        vec_t v;
        v.flush = 0; v.irv = 0; v.aa = 0; v.ba = 0; v.da = 0; v.rw = 0; v.md = 0;
        v.ex_rw = 0; v.ex_da = 0; v.ex_md = 0; v.ex_func = 0;
        v.rw_1 = 0; v.da_1 = 0; v.bus_d = 0;
        v.exp_a = 0; v.exp_b = 0; v.exp_valid = 0; v.exp_rw = 0; v.exp_stall = 0;
        return v;
    endfunction

    function automatic vec_t expect_v(input vec_t v, input logic [31:0] a, input logic [31:0] b,
                                      input logic valid, input logic rw, input logic stall);
        vec_t r = v;
        r.exp_a = a; r.exp_b = b; r.exp_valid = valid; r.exp_rw = rw; r.exp_stall = stall;
        return r;
    endfunction

    task automatic apply(input vec_t v);
        ifc.FLUSH = v.flush; ifc.IR_VALID = v.irv; ifc.AA = v.aa; ifc.BA = v.ba;
        ifc.DA = v.da; ifc.RW = v.rw; ifc.MD = v.md;
        ifc.EX_RW = v.ex_rw; ifc.EX_DA = v.ex_da; ifc.EX_MD = v.ex_md; ifc.EX_FUNC_OUT = v.ex_func;
        ifc.RW_1 = v.rw_1; ifc.DA_1 = v.da_1; ifc.Bus_D = v.bus_d;
    endtask

    // Applies v for one cycle: STALL checked mid-cycle, registered outputs after the edge.
    task automatic step(input string tag, input vec_t v);
        apply(v);
        @(negedge CLK);
        chk({tag, "_stall"}, 32'(ifc.STALL), 32'(v.exp_stall));
        @(posedge CLK); #1;
        chk({tag, "_a"}, ifc.A_OUT, v.exp_a);
        chk({tag, "_b"}, ifc.B_OUT, v.exp_b);
        chk({tag, "_valid"}, 32'(ifc.VALID_OUT), 32'(v.exp_valid));
        chk({tag, "_rw"}, 32'(ifc.RW_OUT), 32'(v.exp_rw));
    endtask

    // Reset, then load r1 into both operands so "hold" is distinguishable from zero.
    task automatic restart();
        vec_t v = blank();
        apply(v);
        reset = 1; @(posedge CLK); #1;
        reset = 0;
        v.irv = 1; v.aa = 1; v.ba = 1;
        apply(v);
        @(posedge CLK); #1;
    endtask

    // Reference model state.
    logic [31:0] m_a, m_b;
    logic [4:0]  m_da;
    logic [1:0]  m_md;
    logic        m_rw, m_valid;
    bit          m_hold;          // previous cycle was a load-use stall
    bit          m_pend, m_cool;  // no-bypass: one more stall owed / settle cycle with no check

    function automatic logic [31:0] ref_op(input logic [4:0] addr);
        if (addr == 0) return 32'h0;
`ifdef OF_BYPASS_EN
        if (!m_hold && ifc.EX_RW && ifc.EX_DA == addr && ifc.EX_MD != 2'd1) return ifc.EX_FUNC_OUT;
        if (ifc.RW_1 && ifc.DA_1 == addr) return ifc.Bus_D;
`endif
        return rfv(int'(addr));
    endfunction

    function automatic bit reads(input logic [4:0] w);
        return w != 0 && (w == ifc.AA || w == ifc.BA);
    endfunction

    vec_t vecs[$];
    vec_t v;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = rfv(i);

        // Reset with a load-use pattern on the inputs: STALL must stay low.
        v = blank();
        v.irv = 1; v.aa = 7; v.ba = 7; v.rw = 1; v.da = 3; v.md = 2;
        v.ex_rw = 1; v.ex_da = 7; v.ex_md = 1;
        apply(v);
        reset = 1;
        @(negedge CLK);
        chk("reset_stall", 32'(ifc.STALL), 0);
        @(posedge CLK); #1;
        chk("reset_a", ifc.A_OUT, 0);
        chk("reset_b", ifc.B_OUT, 0);
        chk("reset_da", 32'(ifc.DA_OUT), 0);
        chk("reset_rw", 32'(ifc.RW_OUT), 0);
        chk("reset_md", 32'(ifc.MD_OUT), 0);
        chk("reset_valid", 32'(ifc.VALID_OUT), 0);
        reset = 0;

        // Single-cycle vectors, each from a fresh state with r1 preloaded.
        v = blank(); v.irv = 1; v.aa = 22; v.ba = 3; v.rw = 1; v.da = 9;
        vecs.push_back(expect_v(v, 32'h45A0F123, rfv(3), 1, 1, 0));

        v = blank(); v.irv = 1; v.aa = 2; v.ba = 5; v.rw = 1;
        v.ex_rw = 1; v.ex_da = 5; v.ex_md = 0; v.ex_func = 32'h09A0FFF3;
`ifdef OF_BYPASS_EN
        vecs.push_back(expect_v(v, rfv(2), 32'h09A0FFF3, 1, 1, 0));
`else
        vecs.push_back(expect_v(v, rfv(1), rfv(1), 0, 0, 1));
`endif

        v = blank(); v.irv = 1; v.aa = 5; v.ba = 6;
        v.rw_1 = 1; v.da_1 = 5; v.bus_d = 32'hFECDA097;
`ifdef OF_BYPASS_EN
        vecs.push_back(expect_v(v, 32'hFECDA097, rfv(6), 1, 0, 0));
`else
        vecs.push_back(expect_v(v, rfv(1), rfv(1), 0, 0, 1));
`endif

        v = blank(); v.irv = 1; v.aa = 0; v.ba = 0; v.rw = 1;
        v.ex_rw = 1; v.ex_da = 0; v.ex_func = 32'h12345678;
        v.rw_1 = 1; v.da_1 = 0; v.bus_d = 32'h87654321;
        vecs.push_back(expect_v(v, 0, 0, 1, 1, 0));

        v = blank(); v.irv = 1; v.aa = 5; v.ba = 5;
        v.ex_rw = 1; v.ex_da = 5; v.ex_md = 2; v.ex_func = 32'hAAAA0001;
        v.rw_1 = 1; v.da_1 = 5; v.bus_d = 32'hBBBB0002;
`ifdef OF_BYPASS_EN
        vecs.push_back(expect_v(v, 32'hAAAA0001, 32'hAAAA0001, 1, 0, 0));
`else
        vecs.push_back(expect_v(v, rfv(1), rfv(1), 0, 0, 1));
`endif

        v = blank(); v.irv = 0; v.rw = 1; v.aa = 3; v.ba = 4;
        vecs.push_back(expect_v(v, rfv(3), rfv(4), 0, 0, 0));

        v = blank(); v.irv = 1; v.aa = 7; v.ba = 2; v.rw = 1;
        v.ex_rw = 1; v.ex_da = 7; v.ex_md = 1;
        vecs.push_back(expect_v(v, rfv(1), rfv(1), 0, 0, 1));

        v.flush = 1;
        vecs.push_back(expect_v(v, rfv(1), rfv(1), 0, 0, 0));

        v.flush = 0; v.irv = 0;
        vecs.push_back(expect_v(v, rfv(7), rfv(2), 0, 0, 0));

        v = blank(); v.irv = 1; v.aa = 3; v.ba = 7;
        v.ex_rw = 1; v.ex_da = 7; v.ex_md = 1;
        vecs.push_back(expect_v(v, rfv(1), rfv(1), 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            restart();
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Load-use, then the load reaches WB while EX carries a non-load to r7.
        restart();
        v = blank(); v.irv = 1; v.aa = 7; v.ba = 2; v.rw = 1;
        v.ex_rw = 1; v.ex_da = 7; v.ex_md = 1;
        step("lu0", expect_v(v, rfv(1), rfv(1), 0, 0, 1));
        v.ex_md = 0; v.ex_func = 32'h11111111;
        v.rw_1 = 1; v.da_1 = 7; v.bus_d = 32'hCAFEF00D;
`ifdef OF_BYPASS_EN
        step("lu1", expect_v(v, 32'hCAFEF00D, rfv(2), 1, 1, 0));
`else
        step("lu1", expect_v(v, rfv(1), rfv(1), 0, 0, 1));
        step("lu2", expect_v(v, rfv(7), rfv(2), 1, 1, 0));
`endif

        // Flush during a hazard leaves the FSM in RUN: the same hazard stalls again.
        restart();
        v = blank(); v.irv = 1; v.aa = 7; v.ba = 2; v.rw = 1;
        v.ex_rw = 1; v.ex_da = 7; v.ex_md = 1; v.flush = 1;
        step("fl0", expect_v(v, rfv(1), rfv(1), 0, 0, 0));
        v.flush = 0;
        step("fl1", expect_v(v, rfv(1), rfv(1), 0, 0, 1));

        // Reset in the middle of a hold: outputs cleared, hold abandoned.
        restart();
        v = blank(); v.irv = 1; v.aa = 7; v.ba = 2; v.rw = 1;
        v.ex_rw = 1; v.ex_da = 7; v.ex_md = 1;
        step("rh0", expect_v(v, rfv(1), rfv(1), 0, 0, 1));
        v = blank(); v.irv = 1; v.aa = 3; v.ba = 4; v.rw = 1; v.da = 5; v.md = 2;
        reset = 1;
        step("rh1", expect_v(v, 0, 0, 0, 0, 0));
        reset = 0;
`ifdef OF_BYPASS_EN
        v.ex_rw = 1; v.ex_da = 3; v.ex_md = 0; v.ex_func = 32'h5A5A1234;
        step("rh2", expect_v(v, 32'h5A5A1234, rfv(4), 1, 1, 0));
`else
        step("rh2", expect_v(v, rfv(3), rfv(4), 1, 1, 0));
`endif

        // Randomized run against the reference model.
        for (int i = 0; i < 600; i++) begin
            bit lu, exm, wbm, raw, exp_stall, rst, fl;
            logic [31:0] na, nb;
            rst = (i == 0) || ($urandom_range(0, 39) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            reset = rst;
            ifc.FLUSH = fl;
            ifc.IR_VALID = 1'($urandom_range(0, 3) != 0);
            ifc.AA = 5'($urandom_range(0, 7));
            ifc.BA = 5'($urandom_range(0, 7));
            ifc.DA = 5'($urandom);
            ifc.RW = 1'($urandom);
            ifc.MD = 2'($urandom);
            ifc.EX_RW = 1'($urandom);
            ifc.EX_DA = 5'($urandom_range(0, 7));
            ifc.EX_MD = 2'($urandom);
            ifc.EX_FUNC_OUT = $urandom;
            ifc.RW_1 = 1'($urandom);
            ifc.DA_1 = 5'($urandom_range(0, 7));
            ifc.Bus_D = $urandom;

            lu  = ifc.IR_VALID && ifc.EX_RW && ifc.EX_MD == 2'd1 && reads(ifc.EX_DA);
            exm = ifc.IR_VALID && ifc.EX_RW && reads(ifc.EX_DA);
            wbm = ifc.IR_VALID && ifc.RW_1 && reads(ifc.DA_1);
`ifdef OF_BYPASS_EN
            raw = !m_hold && lu;
`else
            raw = m_pend || (!m_cool && (exm || wbm));
`endif
            exp_stall = raw && !fl && !rst;
            na = ref_op(ifc.AA);
            nb = ref_op(ifc.BA);

            @(negedge CLK);
            chk("rand_stall", 32'(ifc.STALL), 32'(exp_stall));

            if (rst) begin
                m_a = 0; m_b = 0; m_da = 0; m_md = 0; m_rw = 0; m_valid = 0;
            end else if (fl || raw) begin
                m_valid = 0; m_rw = 0;
            end else begin
                m_a = na; m_b = nb; m_da = ifc.DA; m_md = ifc.MD;
                m_valid = ifc.IR_VALID; m_rw = ifc.RW && ifc.IR_VALID;
            end
            if (rst || fl) begin
                m_hold = 0; m_pend = 0; m_cool = 0;
            end else begin
                m_hold = !m_hold && lu;
                if (m_pend) begin m_pend = 0; m_cool = 1; end
                else if (m_cool) m_cool = 0;
                else if (exm) m_pend = 1;
                else if (wbm) m_cool = 1;
            end

            @(posedge CLK); #1;
            chk("rand_a", ifc.A_OUT, m_a);
            chk("rand_b", ifc.B_OUT, m_b);
            chk("rand_da", 32'(ifc.DA_OUT), 32'(m_da));
            chk("rand_md", 32'(ifc.MD_OUT), 32'(m_md));
            chk("rand_rw", 32'(ifc.RW_OUT), 32'(m_rw));
            chk("rand_valid", 32'(ifc.VALID_OUT), 32'(m_valid));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
